// File: rtl/nano_axil_pkg.sv
`default_nettype none
// ============================================================================
// nano_axil_pkg : shared AXI4-Lite MMIO bridge types and window constants
// Revision 1.0
// ============================================================================
package nano_axil_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_e;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Also consumed by the LSU address decode, so keep the two in lockstep.
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h4000_0000;
    localparam logic [31:0] MMIO_MASK_DEFAULT = 32'hF000_0000;

    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_mmio_bridge.sv
`default_nettype none
// ============================================================================
// axil_mmio_bridge : single-outstanding core MMIO load/store to AXI4-Lite master
// Revision 1.0
// ============================================================================
module axil_mmio_bridge
    import nano_axil_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter logic [31:0] MMIO_MASK = MMIO_MASK_DEFAULT,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        is_mmio_o,
    output logic        req_done_o,
    output logic [31:0] req_rdata_o,
    output logic        req_err_o,
    output logic        busy_o,

    output logic [31:0] m_axi_awaddr_o,
    output logic        m_axi_awvalid_o,
    input  logic        m_axi_awready_i,
    output logic [31:0] m_axi_wdata_o,
    output logic [3:0]  m_axi_wstrb_o,
    output logic        m_axi_wvalid_o,
    input  logic        m_axi_wready_i,
    input  logic [1:0]  m_axi_bresp_i,
    input  logic        m_axi_bvalid_i,
    output logic        m_axi_bready_o,
    output logic [31:0] m_axi_araddr_o,
    output logic        m_axi_arvalid_o,
    input  logic        m_axi_arready_i,
    input  logic [31:0] m_axi_rdata_i,
    input  logic [1:0]  m_axi_rresp_i,
    input  logic        m_axi_rvalid_i,
    output logic        m_axi_rready_o
);

    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic [15:0] wdog_q;
    logic        aw_done_q;
    logic        w_done_q;

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        active;
    logic [15:0] wdog_d;
    logic        wdog_expire;

    assign is_mmio_o = in_window(req_addr_i, MMIO_BASE, MMIO_MASK);
    assign busy_o    = (state_q != IDLE);

    assign aw_hs  = m_axi_awvalid_o && m_axi_awready_i;
    assign w_hs   = m_axi_wvalid_o  && m_axi_wready_i;
    assign ar_hs  = m_axi_arvalid_o && m_axi_arready_i;

    // wdog_d counts the current cycle too, so expiry lands the DONE pulse in cycle TIMEOUT.
    assign active      = (state_q != IDLE) && (state_q != DONE);
    assign wdog_d      = wdog_q + 16'd1;
    assign wdog_expire = active && (wdog_d == WDOG_LIMIT);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= IDLE;
            wdog_q          <= 16'd0;
            aw_done_q       <= 1'b0;
            w_done_q        <= 1'b0;
            req_done_o      <= 1'b0;
            req_rdata_o     <= 32'h0;
            req_err_o       <= 1'b0;
            m_axi_awaddr_o  <= 32'h0;
            m_axi_awvalid_o <= 1'b0;
            m_axi_wdata_o   <= 32'h0;
            m_axi_wstrb_o   <= 4'h0;
            m_axi_wvalid_o  <= 1'b0;
            m_axi_bready_o  <= 1'b0;
            m_axi_araddr_o  <= 32'h0;
            m_axi_arvalid_o <= 1'b0;
            m_axi_rready_o  <= 1'b0;
        end else begin
            req_done_o <= 1'b0;
            if (active) begin
                wdog_q <= wdog_d;
            end

            case (state_q)
                IDLE: begin
                    if (req_valid_i && is_mmio_o) begin
                        wdog_q    <= 16'd0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (req_we_i) begin
                            m_axi_awaddr_o  <= req_addr_i;
                            m_axi_wdata_o   <= req_wdata_i;
                            m_axi_wstrb_o   <= req_wstrb_i;
                            m_axi_awvalid_o <= 1'b1;
                            m_axi_wvalid_o  <= 1'b1;
                            state_q         <= WR_REQ;
                        end else begin
                            m_axi_araddr_o  <= req_addr_i;
                            m_axi_arvalid_o <= 1'b1;
                            state_q         <= RD_ADDR;
                        end
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        m_axi_awvalid_o <= 1'b0;
                        aw_done_q       <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi_wvalid_o <= 1'b0;
                        w_done_q       <= 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        m_axi_bready_o <= 1'b1;
                        state_q        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid_i) begin
                        m_axi_bready_o <= 1'b0;
                        req_err_o      <= (m_axi_bresp_i != RESP_OKAY);
                        req_done_o     <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) begin
                        m_axi_arvalid_o <= 1'b0;
                        m_axi_rready_o  <= 1'b1;
                        state_q         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid_i) begin
                        m_axi_rready_o <= 1'b0;
                        req_rdata_o    <= m_axi_rdata_i;
                        req_err_o      <= (m_axi_rresp_i != RESP_OKAY);
                        req_done_o     <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Abandoning a live handshake breaks AXI rules; the peripheral is treated as dead.
            if (wdog_expire) begin
                m_axi_awvalid_o <= 1'b0;
                m_axi_wvalid_o  <= 1'b0;
                m_axi_bready_o  <= 1'b0;
                m_axi_arvalid_o <= 1'b0;
                m_axi_rready_o  <= 1'b0;
                req_err_o       <= 1'b1;
                req_rdata_o     <= 32'h0;
                req_done_o      <= 1'b1;
                state_q         <= DONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_mmio_bridge.sv
`default_nettype none
// ============================================================================
// tb_axil_mmio_bridge : directed scoreboard bench for axil_mmio_bridge
// Revision 1.0
// ============================================================================
module tb_axil_mmio_bridge;
    import nano_axil_pkg::*;

    localparam int unsigned TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        req_valid_i;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_wstrb_i;
    logic        is_mmio_o;
    logic        req_done_o;
    logic [31:0] req_rdata_o;
    logic        req_err_o;
    logic        busy_o;
    logic [31:0] m_axi_awaddr_o;
    logic        m_axi_awvalid_o;
    logic        m_axi_awready_i;
    logic [31:0] m_axi_wdata_o;
    logic [3:0]  m_axi_wstrb_o;
    logic        m_axi_wvalid_o;
    logic        m_axi_wready_i;
    logic [1:0]  m_axi_bresp_i;
    logic        m_axi_bvalid_i;
    logic        m_axi_bready_o;
    logic [31:0] m_axi_araddr_o;
    logic        m_axi_arvalid_o;
    logic        m_axi_arready_i;
    logic [31:0] m_axi_rdata_i;
    logic [1:0]  m_axi_rresp_i;
    logic        m_axi_rvalid_i;
    logic        m_axi_rready_o;

    axil_mmio_bridge #(
        .MMIO_BASE (32'h4000_0000),
        .MMIO_MASK (32'hF000_0000),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .req_valid_i     (req_valid_i),
        .req_we_i        (req_we_i),
        .req_addr_i      (req_addr_i),
        .req_wdata_i     (req_wdata_i),
        .req_wstrb_i     (req_wstrb_i),
        .is_mmio_o       (is_mmio_o),
        .req_done_o      (req_done_o),
        .req_rdata_o     (req_rdata_o),
        .req_err_o       (req_err_o),
        .busy_o          (busy_o),
        .m_axi_awaddr_o  (m_axi_awaddr_o),
        .m_axi_awvalid_o (m_axi_awvalid_o),
        .m_axi_awready_i (m_axi_awready_i),
        .m_axi_wdata_o   (m_axi_wdata_o),
        .m_axi_wstrb_o   (m_axi_wstrb_o),
        .m_axi_wvalid_o  (m_axi_wvalid_o),
        .m_axi_wready_i  (m_axi_wready_i),
        .m_axi_bresp_i   (m_axi_bresp_i),
        .m_axi_bvalid_i  (m_axi_bvalid_i),
        .m_axi_bready_o  (m_axi_bready_o),
        .m_axi_araddr_o  (m_axi_araddr_o),
        .m_axi_arvalid_o (m_axi_arvalid_o),
        .m_axi_arready_i (m_axi_arready_i),
        .m_axi_rdata_i   (m_axi_rdata_i),
        .m_axi_rresp_i   (m_axi_rresp_i),
        .m_axi_rvalid_i  (m_axi_rvalid_i),
        .m_axi_rready_o  (m_axi_rready_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc = cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    // Scoreboard: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_n_i === 1'b1 && req_done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk1("unexpected_done", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk32("done_latency", 32'(cyc - e.acc), 32'(e.lat));
                chk1("req_err", req_err_o, e.err);
                if (e.chk_rd) chk32("req_rdata", req_rdata_o, e.rdata);
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp_rd, input logic exp_err,
                          input logic chk_rd, input int lat);
        exp_t e;
        int   n;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_wstrb_i = wstrb;
        e.rdata = exp_rd; e.err = exp_err; e.chk_rd = chk_rd; e.lat = lat; e.acc = cyc;
        exp_q.push_back(e);
        #1 chk1("is_mmio", is_mmio_o, 1'b1);
        @(negedge clk_i);
        chk1("busy", busy_o, 1'b1);
        n = 1;
        while (req_done_o !== 1'b1 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk1("done_seen", req_done_o, 1'b1);
        req_valid_i = 1'b0;
    endtask

    task automatic slave_aw(input int wait_n, input logic [31:0] exp_addr);
        int n = 0;
        while (m_axi_awvalid_o !== 1'b1 && n < 20) begin @(negedge clk_i); n++; end
        chk1("awvalid_seen", m_axi_awvalid_o, 1'b1);
        repeat (wait_n) begin
            chk1("awvalid_hold", m_axi_awvalid_o, 1'b1);
            @(negedge clk_i);
        end
        chk32("awaddr", m_axi_awaddr_o, exp_addr);
        m_axi_awready_i = 1'b1;
        @(negedge clk_i);
        m_axi_awready_i = 1'b0;
        chk1("awvalid_drop", m_axi_awvalid_o, 1'b0);
    endtask

    task automatic slave_w(input int wait_n, input logic [31:0] exp_data, input logic [3:0] exp_strb);
        int n = 0;
        while (m_axi_wvalid_o !== 1'b1 && n < 20) begin @(negedge clk_i); n++; end
        chk1("wvalid_seen", m_axi_wvalid_o, 1'b1);
        repeat (wait_n) begin
            chk1("wvalid_hold", m_axi_wvalid_o, 1'b1);
            chk32("wdata_stable", m_axi_wdata_o, exp_data);
            chk1("bready_early", m_axi_bready_o, 1'b0);
            @(negedge clk_i);
        end
        chk32("wdata", m_axi_wdata_o, exp_data);
        chk32("wstrb", 32'(m_axi_wstrb_o), 32'(exp_strb));
        m_axi_wready_i = 1'b1;
        @(negedge clk_i);
        m_axi_wready_i = 1'b0;
        chk1("wvalid_drop", m_axi_wvalid_o, 1'b0);
    endtask

    task automatic slave_b(input int wait_n, input logic [1:0] resp, input logic give);
        int n = 0;
        while (m_axi_bready_o !== 1'b1 && n < 20) begin @(negedge clk_i); n++; end
        chk1("bready_seen", m_axi_bready_o, 1'b1);
        if (give) begin
            repeat (wait_n) @(negedge clk_i);
            m_axi_bvalid_i = 1'b1;
            m_axi_bresp_i  = resp;
            @(negedge clk_i);
            m_axi_bvalid_i = 1'b0;
            m_axi_bresp_i  = RESP_OKAY;
        end
    endtask

    task automatic slave_write(input int aw_wait, input int w_wait, input int b_wait,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [1:0] resp, input logic give);
        fork
            slave_aw(aw_wait, addr);
            slave_w(w_wait, data, strb);
        join
        slave_b(b_wait, resp, give);
    endtask

    task automatic slave_read(input int ar_wait, input int r_wait, input logic [31:0] addr,
                              input logic [31:0] data, input logic [1:0] resp);
        int n = 0;
        while (m_axi_arvalid_o !== 1'b1 && n < 20) begin @(negedge clk_i); n++; end
        chk1("arvalid_seen", m_axi_arvalid_o, 1'b1);
        repeat (ar_wait) begin
            chk1("arvalid_hold", m_axi_arvalid_o, 1'b1);
            chk32("araddr_stable", m_axi_araddr_o, addr);
            @(negedge clk_i);
        end
        chk32("araddr", m_axi_araddr_o, addr);
        m_axi_arready_i = 1'b1;
        @(negedge clk_i);
        m_axi_arready_i = 1'b0;
        chk1("arvalid_drop", m_axi_arvalid_o, 1'b0);
        n = 0;
        while (m_axi_rready_o !== 1'b1 && n < 20) begin @(negedge clk_i); n++; end
        chk1("rready_seen", m_axi_rready_o, 1'b1);
        repeat (r_wait) @(negedge clk_i);
        m_axi_rvalid_i = 1'b1;
        m_axi_rdata_i  = data;
        m_axi_rresp_i  = resp;
        @(negedge clk_i);
        m_axi_rvalid_i = 1'b0;
        m_axi_rdata_i  = 32'h0;
        m_axi_rresp_i  = RESP_OKAY;
    endtask

    task automatic chk_all_zero(input string tag);
        chk32({tag, "_valids"}, {27'h0, m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o,
                                 m_axi_arvalid_o, m_axi_rready_o}, 32'h0);
        chk32({tag, "_status"}, {29'h0, req_done_o, req_err_o, busy_o}, 32'h0);
        chk32({tag, "_rdata"}, req_rdata_o, 32'h0);
        chk32({tag, "_awaddr"}, m_axi_awaddr_o, 32'h0);
        chk32({tag, "_wdata"}, m_axi_wdata_o, 32'h0);
        chk32({tag, "_wstrb"}, 32'(m_axi_wstrb_o), 32'h0);
        chk32({tag, "_araddr"}, m_axi_araddr_o, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n_i = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 32'h0;
        req_wdata_i = 32'h0; req_wstrb_i = 4'h0;
        m_axi_awready_i = 1'b0; m_axi_wready_i = 1'b0;
        m_axi_bvalid_i = 1'b0; m_axi_bresp_i = RESP_OKAY;
        m_axi_arready_i = 1'b0; m_axi_rvalid_i = 1'b0;
        m_axi_rdata_i = 32'h0; m_axi_rresp_i = RESP_OKAY;
        #1 chk_all_zero("reset");
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Zero-wait store: done in cycle 3.
        fork
            do_req(1'b1, 32'h4000_0004, 32'hA5A5_0001, 4'hF, 32'h0, 1'b0, 1'b0, 3);
            slave_write(0, 0, 0, 32'h4000_0004, 32'hA5A5_0001, 4'hF, RESP_OKAY, 1'b1);
        join
        @(negedge clk_i);

        // Load with arready 2 late, rvalid 2 late: done in cycle 7.
        fork
            do_req(1'b0, 32'h4000_0008, 32'h0, 4'h0, 32'h0000_00FF, 1'b0, 1'b1, 7);
            slave_read(2, 2, 32'h4000_0008, 32'h0000_00FF, RESP_OKAY);
        join
        repeat (3) @(negedge clk_i);
        chk32("rdata_hold", req_rdata_o, 32'h0000_00FF);

        // Store with wready 4 cycles after awready.
        fork
            do_req(1'b1, 32'h4000_0010, 32'h1234_ABCD, 4'h3, 32'h0, 1'b0, 1'b0, 7);
            slave_write(0, 4, 0, 32'h4000_0010, 32'h1234_ABCD, 4'h3, RESP_OKAY, 1'b1);
        join
        @(negedge clk_i);

        // Load with SLVERR: data still returned as received.
        fork
            do_req(1'b0, 32'h4000_0020, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 1'b1, 3);
            slave_read(0, 0, 32'h4000_0020, 32'hDEAD_BEEF, RESP_SLVERR);
        join
        @(negedge clk_i);

        // Non-MMIO request is ignored.
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h0000_1000;
        #1 chk1("non_mmio_is_mmio", is_mmio_o, 1'b0);
        repeat (5) begin
            @(negedge clk_i);
            chk32("non_mmio_idle", {28'h0, busy_o, m_axi_awvalid_o, m_axi_wvalid_o, m_axi_arvalid_o}, 32'h0);
        end
        req_valid_i = 1'b0;
        @(negedge clk_i);

        // Unresponsive slave: watchdog fires, done in cycle TO.
        do_req(1'b0, 32'h4000_0030, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, TO);
        chk32("timeout_valids", {30'h0, m_axi_arvalid_o, m_axi_rready_o}, 32'h0);
        @(negedge clk_i);

        // Load OK after timeout, one arready wait.
        fork
            do_req(1'b0, 32'h4000_0040, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1'b1, 4);
            slave_read(1, 0, 32'h4000_0040, 32'h1234_5678, RESP_OKAY);
        join
        @(negedge clk_i);

        // Store with bresp SLVERR after one wait.
        fork
            do_req(1'b1, 32'h4000_0050, 32'h0000_5555, 4'h1, 32'h0, 1'b1, 1'b0, 4);
            slave_write(0, 0, 1, 32'h4000_0050, 32'h0000_5555, 4'h1, RESP_SLVERR, 1'b1);
        join
        @(negedge clk_i);

        // Reset while waiting in WR_RESP.
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h4000_0060;
        req_wdata_i = 32'hCAFE_0060; req_wstrb_i = 4'hF;
        slave_write(0, 0, 0, 32'h4000_0060, 32'hCAFE_0060, 4'hF, RESP_OKAY, 1'b0);
        #2 rst_n_i = 1'b0;
        #1 chk_all_zero("midreset");
        req_valid_i = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        fork
            do_req(1'b1, 32'h4000_0070, 32'h0BAD_F00D, 4'hC, 32'h0, 1'b0, 1'b0, 3);
            slave_write(0, 0, 0, 32'h4000_0070, 32'h0BAD_F00D, 4'hC, RESP_OKAY, 1'b1);
        join
        repeat (2) @(negedge clk_i);
        chk32("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
